// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Shares one RAM port between instruction and data requesters,
//            data-first with a starvation bound on instruction requests.
// Revision : 1.0  initial release
// ============================================================================
module memory_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramrdy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] store_q, store_d;
   logic        wr_q, wr_d;
   logic [3:0]  starve_q, starve_d;
   logic [31:0] iload_q, iload_d;
   logic [31:0] dload_q, dload_d;

   logic w_data_req;
   logic w_starved;
   logic w_grant_d;
   logic w_grant_i;
   logic w_done_i;
   logic w_done_d;

   assign w_data_req = dREN | dWEN;
   assign w_starved  = iREN && (starve_q == C_STARVE_MAX);
   assign w_grant_d  = (state_q == IDLE) && w_data_req && !w_starved;
   assign w_grant_i  = (state_q == IDLE) && !w_grant_d && iREN;
   assign w_done_i   = (state_q == SERVE_I) && ramrdy;
   assign w_done_d   = (state_q == SERVE_D) && ramrdy;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      store_d  = store_q;
      wr_d     = wr_q;
      starve_d = starve_q;
      iload_d  = iload_q;
      dload_d  = dload_q;
      case (state_q)
         IDLE: begin
            if (w_grant_d) begin
               state_d = SERVE_D;
               addr_d  = daddr;
               store_d = dstore;
               wr_d    = dWEN;
               if (!iREN) begin
                  starve_d = 4'd0;
               end else if (starve_q != C_STARVE_MAX) begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (w_grant_i) begin
               state_d  = SERVE_I;
               addr_d   = iaddr;
               starve_d = 4'd0;
            end
         end
         SERVE_I: begin
            if (ramrdy) begin
               state_d = IDLE;
               iload_d = ramload;
            end
         end
         SERVE_D: begin
            if (ramrdy) begin
               state_d = IDLE;
               // Writes complete without disturbing the last read value.
               if (!wr_q) begin
                  dload_d = ramload;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         addr_q   <= 32'd0;
         store_q  <= 32'd0;
         wr_q     <= 1'b0;
         starve_q <= 4'd0;
         iload_q  <= 32'd0;
         dload_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         wr_q     <= wr_d;
         starve_q <= starve_d;
         iload_q  <= iload_d;
         dload_q  <= dload_d;
      end
   end

   // RAM port is driven purely from state and the values latched at grant.
   assign ramREN   = (state_q == SERVE_I) || ((state_q == SERVE_D) && !wr_q);
   assign ramWEN   = (state_q == SERVE_D) && wr_q;
   assign ramaddr  = addr_q;
   assign ramstore = store_q;

   assign iwait = !w_done_i;
   assign dwait = !w_done_d;
   assign iload = w_done_i ? ramload : iload_q;
   assign dload = w_done_d ? ramload : dload_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Directed self-checking bench for memory_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_memory_arbiter;

   logic        CLK;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ramrdy;

   int n_chk;
   int n_fail;

   memory_arbiter #(.STARVE_MAX(4)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramrdy   (ramrdy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and checks happen mid-cycle.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Expected RAM enable pattern per grant during the starvation run: {ramREN, ramWEN}.
   logic [1:0] starve_exp [6];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b1;
      iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
      ramload = 32'h0; ramrdy = 1'b0;

      // Reset with every request asserted
      tick();
      tick();
      check("rst_iwait",  {31'd0, iwait},  32'd1);
      check("rst_dwait",  {31'd0, dwait},  32'd1);
      check("rst_ramREN", {31'd0, ramREN}, 32'd0);
      check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
      check("rst_iload",  iload,  32'd0);
      check("rst_dload",  dload,  32'd0);
      check("rst_ramaddr", ramaddr, 32'd0);
      RST = 1'b0;
      tick();
      check("first_grant_wen", {31'd0, ramWEN}, 32'd1);
      check("first_grant_ren", {31'd0, ramREN}, 32'd0);
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramrdy = 1'b1;
      #1;
      check("first_grant_dwait", {31'd0, dwait}, 32'd0);
      tick();
      ramrdy = 1'b0;
      #1;
      check("first_idle_wen", {31'd0, ramWEN}, 32'd0);

      // Instruction read with three RAM wait cycles
      iREN = 1'b1; iaddr = 32'h40;
      tick();
      iaddr = 32'h44;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("ird_ren",   {31'd0, ramREN}, 32'd1);
         check("ird_addr",  ramaddr, 32'h40);
         check("ird_iwait", {31'd0, iwait},  32'd1);
         tick();
      end
      ramrdy = 1'b1; ramload = 32'hDEADBEEF; iREN = 1'b0;
      #1;
      check("ird_done_iwait", {31'd0, iwait}, 32'd0);
      check("ird_done_iload", iload, 32'hDEADBEEF);
      tick();
      ramrdy = 1'b0; ramload = 32'h0;
      #1;
      check("ird_hold_iwait", {31'd0, iwait},  32'd1);
      check("ird_hold_iload", iload, 32'hDEADBEEF);
      check("ird_hold_ren",   {31'd0, ramREN}, 32'd0);

      // Simultaneous requests: data first, idle gap, then instruction
      iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
      tick();
      check("sim_d_ren",  {31'd0, ramREN}, 32'd1);
      check("sim_d_wen",  {31'd0, ramWEN}, 32'd0);
      check("sim_d_addr", ramaddr, 32'h100);
      ramrdy = 1'b1; ramload = 32'h12345678; dREN = 1'b0;
      #1;
      check("sim_d_dwait", {31'd0, dwait}, 32'd0);
      check("sim_d_iwait", {31'd0, iwait}, 32'd1);
      check("sim_d_dload", dload, 32'h12345678);
      tick();
      ramrdy = 1'b0; ramload = 32'h0;
      #1;
      check("sim_idle_ren",  {31'd0, ramREN}, 32'd0);
      check("sim_idle_dload", dload, 32'h12345678);
      tick();
      check("sim_i_ren",  {31'd0, ramREN}, 32'd1);
      check("sim_i_addr", ramaddr, 32'h80);
      ramrdy = 1'b1; ramload = 32'hCAFEF00D; iREN = 1'b0;
      #1;
      check("sim_i_iwait", {31'd0, iwait}, 32'd0);
      check("sim_i_iload", iload, 32'hCAFEF00D);
      tick();
      ramrdy = 1'b0; ramload = 32'h0;

      // Starvation: four data writes, one instruction read, then data again
      starve_exp[0] = 2'b01; starve_exp[1] = 2'b01; starve_exp[2] = 2'b01;
      starve_exp[3] = 2'b01; starve_exp[4] = 2'b10; starve_exp[5] = 2'b01;
      iREN = 1'b1; iaddr = 32'h48; dWEN = 1'b1;
      for (int k = 0; k < 6; k++) begin
         daddr  = 32'h1000 + 32'(k);
         dstore = 32'hA000 + 32'(k);
         tick();
         check($sformatf("starve_grant%0d", k), {30'd0, ramREN, ramWEN}, {30'd0, starve_exp[k]});
         ramrdy = 1'b1; ramload = 32'h11110000 + 32'(k);
         #1;
         if (starve_exp[k] == 2'b10) begin
            check($sformatf("starve_iwait%0d", k), {31'd0, iwait}, 32'd0);
            check($sformatf("starve_iload%0d", k), iload, 32'h11110000 + 32'(k));
         end else begin
            check($sformatf("starve_dwait%0d", k), {31'd0, dwait}, 32'd0);
            check($sformatf("starve_wdata%0d", k), ramstore, 32'hA000 + 32'(k));
         end
         tick();
         ramrdy = 1'b0; ramload = 32'h0;
      end
      iREN = 1'b0; dWEN = 1'b0;
      #1;
      check("starve_dload_kept", dload, 32'h12345678);
      tick();

      // ramrdy while idle has no effect
      ramrdy = 1'b1;
      #1;
      check("idle_rdy_iwait", {31'd0, iwait}, 32'd1);
      check("idle_rdy_dwait", {31'd0, dwait}, 32'd1);
      ramrdy = 1'b0;

      // Write precedence and latching against mid-service input changes
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h5A5A5A5A;
      tick();
      dREN = 1'b0; dWEN = 1'b0; daddr = 32'h300; dstore = 32'h0;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("wr_wen",   {31'd0, ramWEN}, 32'd1);
         check("wr_ren",   {31'd0, ramREN}, 32'd0);
         check("wr_addr",  ramaddr,  32'h200);
         check("wr_store", ramstore, 32'h5A5A5A5A);
         check("wr_dwait", {31'd0, dwait}, 32'd1);
         tick();
      end
      ramrdy = 1'b1; ramload = 32'hFFFFFFFF;
      #1;
      check("wr_done_dwait", {31'd0, dwait}, 32'd0);
      tick();
      ramrdy = 1'b0; ramload = 32'h0;
      #1;
      check("wr_dload_kept", dload, 32'h12345678);
      check("wr_idle_addr",  ramaddr, 32'h200);
      check("wr_idle_wen",   {31'd0, ramWEN}, 32'd0);

      // Reset in the middle of a data read
      iREN = 1'b1; iaddr = 32'h50; dREN = 1'b1; daddr = 32'h400;
      tick();
      check("mrst_ren",  {31'd0, ramREN}, 32'd1);
      check("mrst_addr", ramaddr, 32'h400);
      RST = 1'b1; iREN = 1'b0; dREN = 1'b0;
      #1;
      check("mrst_dwait_pre", {31'd0, dwait}, 32'd1);
      tick();
      check("mrst_ren_low",  {31'd0, ramREN}, 32'd0);
      check("mrst_wen_low",  {31'd0, ramWEN}, 32'd0);
      check("mrst_dwait",    {31'd0, dwait},  32'd1);
      check("mrst_addr_clr", ramaddr, 32'd0);
      check("mrst_dload",    dload,   32'd0);
      check("mrst_starve",   {28'd0, dut.starve_q}, 32'd0);
      RST = 1'b0;
      tick();
      check("mrst_idle_ren",   {31'd0, ramREN}, 32'd0);
      check("mrst_idle_dwait", {31'd0, dwait},  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates the single RAM port between the instruction-fetch and data-access request streams that the cache block drives out through its memory-side interface. Each stream is granted one RAM transaction at a time, the requester is held off with its wait signal until the RAM completes, and load data is steered back to the granted requester. Data requests win by default. A starvation counter forces an instruction grant after a bounded number of consecutive data grants.

## Interface
Parameters:
- STARVE_MAX, 4: consecutive data grants tolerated while an instruction request is pending; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  low only in the cycle the instruction transaction completes.
- iload  out  32  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are high.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  low only in the cycle the data transaction completes.
- dload  out  32  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data; valid when ramrdy is high.
- ramrdy  in  1  RAM completion strobe for the current access; may assert in the first access cycle.

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE, grant decision:
  - If dREN|dWEN is high and NOT (iREN && starve_cnt == STARVE_MAX): go to SERVE_D.
  - Else if iREN is high: go to SERVE_I.
  - Else: stay in IDLE.
- Latching at the grant edge:
  - The granted address is latched.
  - For a data grant, dstore and a write flag (dWEN) are also latched.
  - Latched values drive the RAM for the whole service. Requester inputs may change mid-service without effect.
- RAM outputs are derived from the state and the latched registers:
  - SERVE_I: ramREN=1, ramWEN=0.
  - SERVE_D write: ramWEN=1, ramREN=0.
  - SERVE_D read: ramREN=1, ramWEN=0.
  - IDLE: both enables 0; ramaddr/ramstore hold their latched values.
- Completion (SERVE_x && ramrdy):
  - The matching wait output goes low in that same cycle.
  - The matching load output is driven from ramload in that same cycle, and the value is captured into a hold register.
  - Next state is IDLE. The mandatory IDLE cycle lets the requester drop its stale request before re-arbitration.
- Load outputs:
  - iload = (SERVE_I && ramrdy) ? ramload : iload_q.
  - dload is formed the same way with SERVE_D.
  - A data write never updates dload_q.
- Wait outputs:
  - iwait = !(SERVE_I && ramrdy).
  - dwait = !(SERVE_D && ramrdy).
  - Both are high whenever there is no request.
- starve_cnt (4 bits), updated at each grant edge:
  - Data grant with iREN high: increment, saturating at STARVE_MAX.
  - Instruction grant: clear to 0.
  - Data grant with iREN low: clear to 0.
- A request withdrawn during service does not abort the access: the access runs until ramrdy and the wait pulse is still produced.

## Timing
- Reset values:
  - State IDLE; starve_cnt 0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iload=0, dload=0, iwait=1, dwait=1.
- Reset mid-service: at the first edge with RST high, the state returns to IDLE and the RAM enables are low from the following cycle. The pending transaction is dropped and no wait pulse is produced.
- Latency:
  - A request seen in IDLE at cycle t puts the RAM access on the port at t+1.
  - With zero-wait RAM (ramrdy at t+1), the wait output is low at t+1 and the state is IDLE at t+2.
  - Minimum issue interval is 2 cycles per transaction.
- ramrdy sampled in IDLE is ignored.

## Test plan
- Reset: hold RST for 2 cycles with all requests high -> iwait=dwait=1, ramREN=ramWEN=0, iload=dload=0; first grant occurs in the cycle after RST deasserts.
- Instruction read: iREN=1, iaddr=0x40, RAM returns 0xDEADBEEF after 3 wait cycles -> ramREN=1 and ramaddr=0x40 for 3 cycles; iwait low for exactly 1 cycle with iload=0xDEADBEEF; iload holds that value afterwards.
- Simultaneous requests: iREN=1 and dREN=1 with daddr=0x100 -> SERVE_D first, dload returned; then IDLE, then SERVE_I.
- Starvation with STARVE_MAX=4: iREN held high while the data requester issues continuous writes (dWEN=1) -> exactly 4 data grants, then an instruction grant, then data resumes.
- Write precedence and latching: dREN=dWEN=1, daddr=0x200, dstore=0x5A5A5A5A, inputs changed mid-service -> ramWEN=1, ramREN=0; ramaddr/ramstore stay 0x200/0x5A5A5A5A until ramrdy; dload unchanged.
- Reset mid-service: assert RST during SERVE_D before ramrdy -> enables drop, no dwait pulse, state IDLE, starve_cnt=0.
